// File: rtl/axi_util_pkg.sv
// -----------------------------------------------------------------------------
// axi_util_pkg
// Shared types for the AXI write-data feeder and its output skid stage.
//   wfeed_state_t : feeder FSM encoding (IDLE / RUN / DONE)
//   bcnt_width()  : width of the in-burst beat counter for a given MAX_BURST
//   wbeat_t       : default-width beat payload {data, last, strb}
// The feeder builds its own beat type sized to its WIDTH parameter. wbeat_t
// is the default payload type of the skid stage.
// -----------------------------------------------------------------------------
package axi_util_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wfeed_state_t;

  localparam int WFEED_DATA_W    = 32;
  localparam int WFEED_MAX_BURST = 16;

  // One spare bit so MAX_BURST-1 always fits, including MAX_BURST==1.
  function automatic int bcnt_width(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

  localparam int WFEED_BCNT_W = bcnt_width(WFEED_MAX_BURST);

  typedef struct packed {
    logic [WFEED_DATA_W-1:0]   data;
    logic                      last;
    logic [WFEED_DATA_W/8-1:0] strb;
  } wbeat_t;

endpackage

// File: rtl/axi_util_skid2.sv
// -----------------------------------------------------------------------------
// axi_util_skid2
// Two-entry output stage: an output register that drives the consumer, plus
// one skid entry that absorbs a beat pushed while the output is stalled.
// Handshake: a beat transfers on o_valid && i_ready. Once o_valid is high it
// stays high with o_beat stable until i_ready. The producer may push only
// when o_can_accept is high, so i_ready never reaches the push side.
// Ports:
//   clk, arst       clock, asynchronous active-high reset
//   i_push_valid    push a beat (only while o_can_accept)
//   i_push_beat     beat payload
//   o_can_accept    skid entry is free
//   o_drained       nothing will be held after this cycle's edge
//   o_valid/o_beat  output register
//   i_ready         consumer accepts the output beat
// -----------------------------------------------------------------------------
module axi_util_skid2
  import axi_util_pkg::*;
#(
  parameter type beat_t = wbeat_t
) (
  input  logic  clk,
  input  logic  arst,
  input  logic  i_push_valid,
  input  beat_t i_push_beat,
  output logic  o_can_accept,
  output logic  o_drained,
  output logic  o_valid,
  input  logic  i_ready,
  output beat_t o_beat
);

  logic  r_out_valid;
  logic  r_skid_valid;
  beat_t r_out;
  beat_t r_skid;
  logic  w_accept;

  assign w_accept     = r_out_valid & i_ready;
  assign o_can_accept = ~r_skid_valid;
  assign o_drained    = ~r_skid_valid & (~r_out_valid | w_accept);
  assign o_valid      = r_out_valid;
  assign o_beat       = r_out;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out        <= '0;
      r_skid       <= '0;
    end else begin
      if (r_skid_valid) begin
        // A push cannot coincide with a full skid entry.
        if (w_accept) begin
          r_out        <= r_skid;
          r_skid_valid <= 1'b0;
        end
      end else if (i_push_valid) begin
        if (!r_out_valid || w_accept) begin
          r_out       <= i_push_beat;
          r_out_valid <= 1'b1;
        end else begin
          r_skid       <= i_push_beat;
          r_skid_valid <= 1'b1;
        end
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_util_wdata_feeder.sv
// -----------------------------------------------------------------------------
// axi_util_wdata_feeder
// Drains a fall-through FIFO and presents the beats on an AXI W channel. A
// command of N beats is split into bursts of at most MAX_BURST beats, with
// w_last on each burst's final beat. A 2-entry skid stage keeps w_ready off
// the combinational path to fifo_read.
// W handshake: a beat transfers on w_valid && w_ready. w_valid, once high,
// holds with w_data/w_last(/w_strb) stable until w_ready.
// Optional feature macro: AXI_UTIL_WDATA_STRB_EN adds cmd_last_strb/w_strb.
// Ports:
//   clk, arst                     clock, asynchronous active-high reset
//   cmd_valid/cmd_ready/cmd_beats transfer command (ready only in IDLE)
//   cmd_last_strb                 final-beat strobe (macro only)
//   fifo_empty/fifo_read/fifo_dout FIFO read side
//   w_valid/w_ready/w_data/w_last AXI W channel
//   w_strb                        W strobe (macro only)
//   done                          one-cycle pulse at transfer completion
//   dbg_state                     current FSM state
// -----------------------------------------------------------------------------
module axi_util_wdata_feeder
  import axi_util_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [CNT_W-1:0]   cmd_beats,
`ifdef AXI_UTIL_WDATA_STRB_EN
  input  logic [WIDTH/8-1:0] cmd_last_strb,
`endif
  input  logic               fifo_empty,
  output logic               fifo_read,
  input  logic [WIDTH-1:0]   fifo_dout,
  output logic               w_valid,
  input  logic               w_ready,
  output logic [WIDTH-1:0]   w_data,
  output logic               w_last,
`ifdef AXI_UTIL_WDATA_STRB_EN
  output logic [WIDTH/8-1:0] w_strb,
`endif
  output logic               done,
  output wfeed_state_t       dbg_state
);

  localparam int BCNT_W = bcnt_width(MAX_BURST);

  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic               last;
`ifdef AXI_UTIL_WDATA_STRB_EN
    logic [WIDTH/8-1:0] strb;
`endif
  } beat_t;

  wfeed_state_t      r_state;
  wfeed_state_t      w_state_nxt;
  logic [CNT_W-1:0]  r_rem;
  logic [BCNT_W-1:0] r_bcnt;
`ifdef AXI_UTIL_WDATA_STRB_EN
  logic [WIDTH/8-1:0] r_last_strb;
`endif

  logic  w_run;
  logic  w_pop;
  logic  w_tag_last;
  logic  w_can_accept;
  logic  w_drained;
  logic  w_cmd_take;
  beat_t w_pop_beat;
  beat_t w_out_beat;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge arst) begin
    if (arst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (cmd_valid) w_state_nxt = (cmd_beats == '0) ? DONE : RUN;
      // Leave RUN only when every popped beat has been handed over.
      RUN:  if ((r_rem == '0) && w_drained) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    done      = 1'b0;
    w_run     = 1'b0;
    case (r_state)
      IDLE:    cmd_ready = 1'b1;
      RUN:     w_run     = 1'b1;
      DONE:    done      = 1'b1;
      default: cmd_ready = 1'b0;
    endcase
  end

  assign dbg_state  = r_state;
  assign w_cmd_take = (r_state == IDLE) && cmd_valid;

  // Pop only from registered state: a free skid entry guarantees room.
  assign w_pop      = w_run && !fifo_empty && (r_rem != '0) && w_can_accept;
  assign fifo_read  = w_pop;
  assign w_tag_last = (r_bcnt == BCNT_W'(MAX_BURST - 1)) || (r_rem == CNT_W'(1));

  // ---------------------------------------------------------- counters
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_rem  <= '0;
      r_bcnt <= '0;
    end else if (w_cmd_take) begin
      r_rem  <= cmd_beats;
      r_bcnt <= '0;
    end else if (w_pop) begin
      r_rem  <= r_rem - CNT_W'(1);
      r_bcnt <= w_tag_last ? '0 : r_bcnt + BCNT_W'(1);
    end
  end

`ifdef AXI_UTIL_WDATA_STRB_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst)            r_last_strb <= '0;
    else if (w_cmd_take) r_last_strb <= cmd_last_strb;
  end
`endif

  always_comb begin
    w_pop_beat      = '0;
    w_pop_beat.data = fifo_dout;
    w_pop_beat.last = w_tag_last;
`ifdef AXI_UTIL_WDATA_STRB_EN
    // Only the transfer's final beat (rem==1) carries the partial strobe.
    w_pop_beat.strb = (r_rem == CNT_W'(1)) ? r_last_strb : '1;
`endif
  end

  // ---------------------------------------------------------- output stage
  axi_util_skid2 #(
    .beat_t(beat_t)
  ) u_skid (
    .clk         (clk),
    .arst        (arst),
    .i_push_valid(w_pop),
    .i_push_beat (w_pop_beat),
    .o_can_accept(w_can_accept),
    .o_drained   (w_drained),
    .o_valid     (w_valid),
    .i_ready     (w_ready),
    .o_beat      (w_out_beat)
  );

  assign w_data = w_out_beat.data;
  assign w_last = w_out_beat.last;
`ifdef AXI_UTIL_WDATA_STRB_EN
  assign w_strb = w_out_beat.strb;
`endif

endmodule

// File: tb/tb_axi_util_wdata_feeder.sv
// -----------------------------------------------------------------------------
// tb_axi_util_wdata_feeder
// Bench for axi_util_wdata_feeder. A queue models the fall-through FIFO; each
// pushed word also produces its expected W beat from the burst rules, so the
// scoreboard needs no knowledge of the feeder's internals. Inputs change
// after the rising edge, outputs are sampled on the falling edge.
// Build with AXI_UTIL_WDATA_STRB_EN defined to exercise the strobe ports.
// -----------------------------------------------------------------------------
module tb_axi_util_wdata_feeder;
  import axi_util_pkg::*;

  localparam int WIDTH     = 32;
  localparam int MAX_BURST = 16;
  localparam int CNT_W     = 16;
  localparam int SW        = WIDTH / 8;
  localparam int EW        = SW + 1 + WIDTH;

  // ------------------------------------------------------ clock / reset
  logic clk  = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  logic             cmd_valid     = 1'b0;
  logic [CNT_W-1:0] cmd_beats     = '0;
  logic [SW-1:0]    cmd_last_strb = '0;
  logic             fifo_empty    = 1'b1;
  logic [WIDTH-1:0] fifo_dout     = '0;
  logic             w_ready       = 1'b0;
  logic             cmd_ready, fifo_read, w_valid, w_last, done;
  logic [WIDTH-1:0] w_data;
  logic [SW-1:0]    w_strb;
  wfeed_state_t     dbg_state;

  axi_util_wdata_feeder #(
    .WIDTH(WIDTH), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_beats    (cmd_beats),
`ifdef AXI_UTIL_WDATA_STRB_EN
    .cmd_last_strb(cmd_last_strb),
`endif
    .fifo_empty   (fifo_empty),
    .fifo_read    (fifo_read),
    .fifo_dout    (fifo_dout),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_data       (w_data),
    .w_last       (w_last),
`ifdef AXI_UTIL_WDATA_STRB_EN
    .w_strb       (w_strb),
`endif
    .done         (done),
    .dbg_state    (dbg_state)
  );

`ifndef AXI_UTIL_WDATA_STRB_EN
  assign w_strb = '0;
`endif

  // ------------------------------------------------------ bench state
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int hs_cnt, pop_cnt, last_cnt, done_cnt, stall_pops;
  int first_pop_cyc, first_hs_cyc, last_hs_cyc, done_cyc, cmd_cyc;
  int ready_mode = 0;           // 0: always ready, 1: random, 2: stalled
  bit pop_seen = 1'b0;
  bit fifo_hold = 1'b0;         // forces the FIFO to look empty
  bit prev_v = 1'b0, prev_r = 1'b0;
  logic [WIDTH:0]   prev_dl = '0;
  logic [WIDTH-1:0] fifo_q[$];
  logic [EW-1:0]    exp_q[$];   // {strb, last, data}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // W-side consumer.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       w_ready = 1'b1;
      1:       w_ready = ($urandom_range(0, 3) != 0);
      default: w_ready = 1'b0;
    endcase
  end

  // Fall-through FIFO model: pops what the DUT read in the previous cycle.
  always @(posedge clk) begin
    #2;
    if (pop_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_empty = (fifo_q.size() == 0) || fifo_hold;
    fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  // ------------------------------------------------------ monitor / scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (arst) begin
      pop_seen = 1'b0;
      prev_v   = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        check("axi_hold_valid", w_valid, 1);
        check("axi_hold_beat", {w_last, w_data}, prev_dl);
      end
      pop_seen = fifo_read;
      if (fifo_read) begin
        check("pop_nonempty", fifo_empty, 0);
        pop_cnt++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        if (!w_ready) stall_pops++;
      end
      if (w_valid && w_ready) begin
        hs_cnt++;
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        if (w_last) last_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL beat_extra: got beat 0x%0h, expected no beat", w_data);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", w_data, e[WIDTH-1:0]);
          check("beat_last", w_last, e[WIDTH]);
`ifdef AXI_UTIL_WDATA_STRB_EN
          check("beat_strb", w_strb, e[EW-1:WIDTH+1]);
`endif
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_v  = w_valid;
      prev_r  = w_ready;
      prev_dl = {w_last, w_data};
    end
  end

  // ------------------------------------------------------ driver tasks
  // Loads n words into the FIFO, queues their expected beats, issues the command.
  task automatic start_xfer(input int n, input logic [SW-1:0] strb);
    int waited;
    logic [WIDTH-1:0] word;
    logic             lst;
    logic [SW-1:0]    stb;
    hs_cnt = 0; pop_cnt = 0; last_cnt = 0; done_cnt = 0; stall_pops = 0;
    first_pop_cyc = -1; first_hs_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    for (int i = 0; i < n; i++) begin
      word = $urandom;
      lst  = (((i + 1) % MAX_BURST) == 0) || (i == n - 1);
      stb  = (i == n - 1) ? strb : {SW{1'b1}};
      fifo_q.push_back(word);
      exp_q.push_back({stb, lst, word});
    end
    @(negedge clk);
    waited = 0;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid     = 1'b1;
    cmd_beats     = n[CNT_W-1:0];
    cmd_last_strb = strb;
    cmd_cyc       = cyc;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Waits (bounded) for done, then checks the per-transfer totals.
  task automatic finish_xfer(input int n, input int exp_lasts, input bit tight, input string tag);
    int budget;
    budget = n * 12 + 60;
    for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_handshakes"}, hs_cnt, n);
    check({tag, "_pops"}, pop_cnt, n);
    check({tag, "_last_count"}, last_cnt, exp_lasts);
    check({tag, "_beats_left"}, exp_q.size(), 0);
    if (n > 0) begin
      check({tag, "_done_after_last"}, done_cyc, last_hs_cyc + 1);
    end else begin
      check({tag, "_zero_done_delay"}, (done_cyc - cmd_cyc >= 1) && (done_cyc - cmd_cyc <= 2), 1);
    end
    if (tight && n > 0) begin
      check({tag, "_back_to_back"}, last_hs_cyc - first_hs_cyc, n - 1);
      check({tag, "_pop_latency"}, first_hs_cyc, first_pop_cyc + 1);
    end
  endtask

  // ------------------------------------------------------ vectors
  typedef struct {
    int    beats;
    int    rmode;
    bit    gap;
    int    exp_lasts;
    string tag;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int   w;
    int   hs_before;
    logic [SW-1:0] s;

    vecs[0] = '{5,  0, 1'b0, 1, "v5"};
    vecs[1] = '{40, 0, 1'b0, 3, "v40"};
    vecs[2] = '{17, 1, 1'b0, 2, "v17_rand"};
    vecs[3] = '{33, 1, 1'b1, 3, "v33_gap"};
    vecs[4] = '{1,  0, 1'b0, 1, "v1"};
    vecs[5] = '{16, 1, 1'b0, 1, "v16_rand"};
    vecs[6] = '{0,  0, 1'b0, 0, "v0"};
    vecs[7] = '{32, 0, 1'b0, 2, "v32"};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_w_valid", w_valid, 0);
    check("rst_w_last", w_last, 0);
    check("rst_w_data", w_data, 0);
    check("rst_done", done, 0);
    check("rst_fifo_read", fifo_read, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_state", dbg_state, IDLE);
`ifdef AXI_UTIL_WDATA_STRB_EN
    check("rst_w_strb", w_strb, 0);
`endif
    arst = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[k]) begin
      ready_mode = vecs[k].rmode;
      s = SW'($urandom_range(1, (1 << SW) - 1));
      start_xfer(vecs[k].beats, s);
      fork
        begin
          if (vecs[k].gap) begin
            repeat (6) @(negedge clk);
            fifo_hold = 1'b1;
            repeat (5) @(negedge clk);
            fifo_hold = 1'b0;
          end
        end
        finish_xfer(vecs[k].beats, vecs[k].exp_lasts,
                    (vecs[k].rmode == 0) && !vecs[k].gap, vecs[k].tag);
      join
    end

    // Long w_ready stall mid-burst.
    ready_mode = 0;
    start_xfer(24, {SW{1'b1}});
    w = 0;
    while (hs_cnt < 3 && w < 100) begin
      @(negedge clk);
      w++;
    end
    stall_pops = 0;
    ready_mode = 2;
    @(posedge clk);
    #2 hs_before = hs_cnt;
    repeat (10) @(posedge clk);
    #2;
    check("stall_pops_max2", stall_pops <= 2, 1);
    check("stall_no_handshake", hs_cnt, hs_before);
    check("stall_valid_held", w_valid, 1);
    ready_mode = 0;
    finish_xfer(24, 2, 1'b0, "stall");

`ifdef AXI_UTIL_WDATA_STRB_EN
    // Partial strobe on the final beat only: 1111, 1111, 0011.
    ready_mode = 0;
    start_xfer(3, 4'b0011);
    finish_xfer(3, 1, 1'b1, "strb3");
`endif

    // Reset mid-burst.
    ready_mode = 1;
    start_xfer(30, {SW{1'b1}});
    w = 0;
    while (hs_cnt < 5 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("mid_rst_reached", hs_cnt >= 5, 1);
    @(negedge clk);
    #2 arst = 1'b1;
    #1;
    check("mid_rst_w_valid", w_valid, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_fifo_read", fifo_read, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_state", dbg_state, IDLE);
    fifo_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    arst = 1'b0;
    repeat (2) @(posedge clk);
    ready_mode = 0;
    start_xfer(5, 4'h3);
    finish_xfer(5, 1, 1'b1, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
